// File: rtl/pong_engine.sv
// pong_engine
// Two-player Pong game core. Keeps paddle, ball, score and game-state
// registers, advances them once per frame and renders a 1-bit object mask
// for the raster position supplied by the VGA timing generator.
//
// Ports
//   CLK, RESET         : single clock, synchronous active-high reset
//   in_animate         : one-cycle end-of-frame strobe; all motion happens here
//   in_x, in_y         : current raster position (in_y zero-extended to 11 bits)
//   in_l_up/in_l_dn    : left paddle controls (level)
//   in_r_up/in_r_dn    : right paddle controls (level)
//   in_start           : start / restart request (level)
//   out_pixel          : raster position lies on a paddle or on the ball
//   out_score_l/_r     : player scores
//   out_state          : 0 IDLE, 1 SERVE, 2 PLAY, 3 GAMEOVER (also the FSM debug view)
//
// Strobe semantics: there is no handshake. in_animate is a qualifier sampled
// on the same CLK edge that commits the frame update; a pulse is consumed
// whenever it is high, and nothing is stalled or acknowledged.

module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PAD_LEN      = 180,
  parameter int PAD_W        = 20,
  parameter int BALL_SIZE    = 20,
  parameter int PAD_SPEED    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_animate,
  input  logic [9:0]         in_x,
  input  logic [8:0]         in_y,
  input  logic               in_l_up,
  input  logic               in_l_dn,
  input  logic               in_r_up,
  input  logic               in_r_dn,
  input  logic               in_start,
  output logic               out_pixel,
  output logic [SCORE_W-1:0] out_score_l,
  output logic [SCORE_W-1:0] out_score_r,
  output logic [1:0]         out_state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SERVE    = 2'd1;
  localparam logic [1:0] S_PLAY     = 2'd2;
  localparam logic [1:0] S_GAMEOVER = 2'd3;

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] K_H_RES   = 11'(H_RES);
  localparam logic [10:0] K_PAD_LEN = 11'(PAD_LEN);
  localparam logic [10:0] K_PAD_W   = 11'(PAD_W);
  localparam logic [10:0] K_BALL    = 11'(BALL_SIZE);
  localparam logic [10:0] K_PSPD    = 11'(PAD_SPEED);
  localparam logic [10:0] K_BSPD    = 11'(BALL_SPEED);
  localparam logic [10:0] K_PAD_MAX = 11'(V_RES - PAD_LEN);
  localparam logic [10:0] K_BY_MAX  = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] K_BX_R    = 11'(H_RES - PAD_W - BALL_SIZE);
  localparam logic [10:0] K_L_ZONE  = 11'(PAD_W + BALL_SPEED);
  localparam logic [10:0] K_R_EDGE  = 11'(H_RES - PAD_W);
  localparam logic [10:0] K_PY0     = 11'((V_RES - PAD_LEN) / 2);
  localparam logic [10:0] K_BX0     = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] K_BY0     = 11'((V_RES - BALL_SIZE) / 2);

  localparam logic [CNT_W-1:0]   K_SERVE   = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   K_CNT_ONE = CNT_W'(1);
  localparam logic [SCORE_W-1:0] K_WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] K_SC_ONE  = SCORE_W'(1);

  logic [1:0]         state, state_n;
  logic [10:0]        ly, ry, bx, by;
  logic [10:0]        ly_n, ry_n, bx_n, by_n;
  logic               dx, dy, dx_n, dy_n;
  logic [SCORE_W-1:0] score_l, score_r, score_l_n, score_r_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  // One paddle step; the clamp is taken before the subtraction so the
  // unsigned position can never wrap below zero.
  function automatic logic [10:0] pad_step(input logic [10:0] y,
                                           input logic up, input logic dn);
    logic [10:0] r;
    r = y;
    if (up && !dn) begin
      r = (y < K_PSPD) ? 11'd0 : (y - K_PSPD);
    end else if (dn && !up) begin
      r = ((y + K_PSPD) > K_PAD_MAX) ? K_PAD_MAX : (y + K_PSPD);
    end
    return r;
  endfunction

  // Candidate vertical move for this frame; discarded on a miss.
  logic [10:0] by_v;
  logic        dy_v;

  always_comb begin
    by_v = by;
    dy_v = dy;
    if (dy) begin
      if ((by + K_BSPD) >= K_BY_MAX) begin
        by_v = K_BY_MAX;
        dy_v = 1'b0;
      end else begin
        by_v = by + K_BSPD;
      end
    end else begin
      if (by <= K_BSPD) begin
        by_v = 11'd0;
        dy_v = 1'b1;
      end else begin
        by_v = by - K_BSPD;
      end
    end
  end

  // Collision terms use the paddle and ball positions from before this frame.
  logic hit_l, hit_r, zone_l, zone_r;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  assign hit_l  = ((by + K_BALL) > ly) && (by < (ly + K_PAD_LEN));
  assign hit_r  = ((by + K_BALL) > ry) && (by < (ry + K_PAD_LEN));
  assign zone_r = dx  && ((bx + K_BSPD) >= K_BX_R);
  assign zone_l = !dx && (bx <= K_L_ZONE);

  assign score_l_inc = (score_l >= K_WIN) ? K_WIN : (score_l + K_SC_ONE);
  assign score_r_inc = (score_r >= K_WIN) ? K_WIN : (score_r + K_SC_ONE);

  always_comb begin
    state_n   = state;
    ly_n      = ly;
    ry_n      = ry;
    bx_n      = bx;
    by_n      = by;
    dx_n      = dx;
    dy_n      = dy;
    score_l_n = score_l;
    score_r_n = score_r;
    cnt_n     = cnt;

    case (state)
      S_IDLE: begin
        // A coincident animate pulse is not counted against the serve delay.
        if (in_start) begin
          state_n = S_SERVE;
          cnt_n   = K_SERVE;
        end
      end

      S_SERVE: begin
        if (in_animate) begin
          ly_n  = pad_step(ly, in_l_up, in_l_dn);
          ry_n  = pad_step(ry, in_r_up, in_r_dn);
          cnt_n = cnt - K_CNT_ONE;
          if (cnt <= K_CNT_ONE) begin
            state_n = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (in_animate) begin
          ly_n = pad_step(ly, in_l_up, in_l_dn);
          ry_n = pad_step(ry, in_r_up, in_r_dn);
          by_n = by_v;
          dy_n = dy_v;
          if (zone_r) begin
            if (hit_r) begin
              bx_n = K_BX_R;
              dx_n = 1'b0;
            end else begin
              // Right player conceded: left scores, ball heads right next.
              score_l_n = score_l_inc;
              bx_n      = K_BX0;
              by_n      = K_BY0;
              dy_n      = dy;
              dx_n      = 1'b1;
              cnt_n     = K_SERVE;
              state_n   = (score_l_inc == K_WIN) ? S_GAMEOVER : S_SERVE;
            end
          end else if (zone_l) begin
            if (hit_l) begin
              bx_n = K_PAD_W;
              dx_n = 1'b1;
            end else begin
              score_r_n = score_r_inc;
              bx_n      = K_BX0;
              by_n      = K_BY0;
              dy_n      = dy;
              dx_n      = 1'b0;
              cnt_n     = K_SERVE;
              state_n   = (score_r_inc == K_WIN) ? S_GAMEOVER : S_SERVE;
            end
          end else begin
            bx_n = dx ? (bx + K_BSPD) : (bx - K_BSPD);
          end
        end
      end

      S_GAMEOVER: begin
        if (in_start) begin
          score_l_n = '0;
          score_r_n = '0;
          bx_n      = K_BX0;
          by_n      = K_BY0;
          dx_n      = 1'b1;
          dy_n      = 1'b1;
          cnt_n     = K_SERVE;
          state_n   = S_SERVE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      ly      <= K_PY0;
      ry      <= K_PY0;
      bx      <= K_BX0;
      by      <= K_BY0;
      dx      <= 1'b1;
      dy      <= 1'b1;
      score_l <= '0;
      score_r <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      ly      <= ly_n;
      ry      <= ry_n;
      bx      <= bx_n;
      by      <= by_n;
      dx      <= dx_n;
      dy      <= dy_n;
      score_l <= score_l_n;
      score_r <= score_r_n;
      cnt     <= cnt_n;
    end
  end

  // Rendering: each object covers [pos, pos+size) on both axes.
  logic [10:0] x, y;
  logic        on_l, on_r, on_b;

  assign x = {1'b0, in_x};
  assign y = {2'b0, in_y};

  assign on_l = (x < K_PAD_W) && (y >= ly) && (y < (ly + K_PAD_LEN));
  assign on_r = (x >= K_R_EDGE) && (x < K_H_RES) && (y >= ry) && (y < (ry + K_PAD_LEN));
  assign on_b = (x >= bx) && (x < (bx + K_BALL)) && (y >= by) && (y < (by + K_BALL));

  assign out_pixel   = on_l | on_r | on_b;
  assign out_score_l = score_l;
  assign out_score_r = score_r;
  assign out_state   = state;

endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised two-player Pong game core. Holds paddle and ball state, applies per-frame motion, wall and paddle collisions, scoring and a serve/play/game-over state machine, and renders a 1-bit pixel mask for the current raster position. It sits between the 640x480 VGA timing generator, which supplies pixel position and the end-of-frame animate strobe, and the VGA colour outputs. It replaces per-object free-running bouncers with player-controlled paddles and real ball/paddle interaction.

## Interface
- H_RES, 640: active width in pixels.
- V_RES, 480: active height in pixels.
- PAD_LEN, 180: paddle height in pixels.
- PAD_W, 20: paddle width in pixels. Left paddle occupies x in [0, PAD_W). Right paddle occupies x in [H_RES-PAD_W, H_RES).
- BALL_SIZE, 20: ball edge length in pixels.
- PAD_SPEED, 4: paddle step, in pixels per frame.
- BALL_SPEED, 2: ball step per axis, in pixels per frame.
- WIN_SCORE, 9: score that ends the game.
- SERVE_FRAMES, 60: number of animate pulses spent in SERVE.
- SCORE_W, 4: width of the score outputs.

Ports:
- CLK, in, 1: board clock. This is the only clock.
- RESET, in, 1: synchronous, active-high reset.
- in_animate, in, 1: one-cycle pulse at end of each frame. All motion happens only on cycles where this is high.
- in_x, in, 10: current pixel x position.
- in_y, in, 9: current pixel y position, zero-extended internally.
- in_l_up, in_l_dn, in_r_up, in_r_dn, in, 1 each: paddle controls, level-sensitive.
- in_start, in, 1: start or restart request, level-sensitive.
- out_pixel, out, 1: high when (in_x, in_y) lies on a paddle or on the ball.
- out_score_l, out_score_r, out, SCORE_W: player scores.
- out_state, out, 2: state encoding. 0 = IDLE, 1 = SERVE, 2 = PLAY, 3 = GAMEOVER.

## Operation
- Registered state:
  - Paddle tops: ly, ry.
  - Ball top-left: bx, by.
  - Ball direction: dx (1 = right), dy (1 = down).
  - Scores and serve counter.
  - FSM state.
- Reset values, and the re-centred position:
  - state = IDLE, scores = 0.
  - ly = ry = (V_RES-PAD_LEN)/2.
  - bx = (H_RES-BALL_SIZE)/2, by = (V_RES-BALL_SIZE)/2. This is also the position used whenever the ball is re-centred.
  - dx = 1, dy = 1.
- FSM:
  - IDLE: in_start on any cycle moves to SERVE and loads the counter with SERVE_FRAMES. In IDLE, nothing else changes.
  - SERVE:
    - Ball is held at the centre.
    - Paddles move.
    - Each animate pulse decrements the counter. The pulse that takes it to 0 moves the state to PLAY.
  - PLAY: paddles and ball move on each animate pulse.
  - GAMEOVER:
    - All positions are frozen.
    - in_start clears both scores, re-centres the ball, sets dx = 1, dy = 1, loads the counter and moves to SERVE.
- Paddle update, per pulse, in SERVE and PLAY:
  - up and not dn: y = max(0, y-PAD_SPEED).
  - dn and not up: y = min(V_RES-PAD_LEN, y+PAD_SPEED).
  - Both or neither: hold.
- Ball vertical update, per PLAY pulse:
  - Moving down with by+BALL_SPEED >= V_RES-BALL_SIZE: by = V_RES-BALL_SIZE and dy = 0.
  - Moving up with by <= BALL_SPEED: by = 0 and dy = 1.
  - Otherwise by steps by BALL_SPEED.
- Ball horizontal update, per PLAY pulse:
  - Moving right with bx+BALL_SPEED >= H_RES-PAD_W-BALL_SIZE: resolve against the right paddle.
  - Moving left with bx <= PAD_W+BALL_SPEED: resolve against the left paddle.
  - Otherwise bx steps by BALL_SPEED.
- Resolve:
  - The overlap test uses pre-update paddle and ball y values: by+BALL_SIZE > py and by < py+PAD_LEN.
  - Hit: clamp bx to the paddle face (H_RES-PAD_W-BALL_SIZE on the right, PAD_W on the left) and invert dx.
  - Miss:
    - The opponent's score increments, saturating at WIN_SCORE.
    - The ball is re-centred and dx points toward the player who conceded.
    - If the new score equals WIN_SCORE the state goes to GAMEOVER. Otherwise it goes to SERVE with the counter loaded.
    - The vertical update of that pulse is discarded.
- Arithmetic:
  - Internal sums are 11 bits unsigned.
  - Clamps are applied before writeback, so no position ever wraps.
- out_pixel is combinational from in_x/in_y and the registers. An object covers [pos, pos+size) on each axis. Rendering is active in all states.

## Timing
- Registers update on the CLK edge of the animate-pulse cycle. New positions are visible the following cycle.
- out_pixel has zero latency relative to in_x/in_y.
- in_start during SERVE or PLAY is ignored.
- in_start and in_animate in the same IDLE cycle: transition to SERVE only. That pulse is not counted.
- RESET wins over every other input. RESET asserted mid-PLAY returns all outputs to reset values at the next edge.

## Test plan
- Reset check. Pulse RESET, then verify:
  - out_state = 0 and both scores = 0.
  - out_pixel = 1 at (320,240), (5,160) and (630,329).
  - out_pixel = 0 at (5,100) and (630,330).
- Serve countdown. Assert in_start, then issue 60 animate pulses: out_state = 1 after pulse 59 and 2 after pulse 60. Ball stays at (310,230) throughout.
- Paddle clamp. Hold in_l_up for 40 SERVE pulses:
  - ly reaches 0 on pulse 38 and holds there.
  - out_pixel = 1 at (5,0).
  - Holding in_l_up and in_l_dn together leaves ly unchanged.
- Miss. With no inputs, on PLAY pulse 145 the ball is at by = 402, missing the right paddle (150..329):
  - out_score_l = 1 and out_state = 1.
  - Ball re-centred to (310,230) with dx = right.
- Hit. Hold in_r_dn from the start of SERVE, so ry = 300. On PLAY pulse 145 the ball bounces: bx = 600, dx = left, scores unchanged.
- Game over and mid-play reset:
  - With WIN_SCORE = 2, two misses give out_state = 3, and further animate pulses change nothing.
  - in_start then gives scores 0 and out_state = 1.
  - RESET asserted mid-PLAY restores the reset values.
